sap1_controller_sequencer: RTL
==============================

// Module: sap1_controller_sequencer
// PURPOSE
//  SAP-1 controller-sequencer: issues the control word that drives every W-bus register.
//  Consumers include the accumulator (La_bar, Ea), B reg, PC, MAR, RAM, IR, ALU and OUT reg.
//  Six-state one-hot ring counter (T1..T6) plus a combinational opcode decoder. Latches HLT.
//  Guarantees at most one W-bus driver per T-state.
// PARAMETERS
//  OP_LDA  4'b0000  load accumulator from RAM[operand]
//  OP_ADD  4'b0001  A <= A + RAM[operand]
//  OP_SUB  4'b0010  A <= A - RAM[operand]
//  OP_OUT  4'b1110  OUT reg <= A
//  OP_HLT  4'b1111  stop ring counter, assert HLT
// PORTS
//  CLK      in   1  system clock; ring counter advances on FALLING edge
//  CLR_bar  in   1  asynchronous, active-low reset
//  opcode   in   4  IR upper nibble, valid from T4 through T6
//  t_state  out  6  one-hot ring counter, bit0=T1 .. bit5=T6
//  Cp       out  1  PC increment enable (high)
//  Ep       out  1  PC drives W bus (high)
//  Lm_bar   out  1  MAR load (low)
//  CE_bar   out  1  RAM drives W bus (low)
//  Li_bar   out  1  IR load (low)
//  Ei       out  1  IR operand nibble drives W bus (high)
//  La_bar   out  1  accumulator load (low)
//  Ea       out  1  accumulator drives W bus (high)
//  Su       out  1  ALU subtract select (1=sub, 0=add)
//  Eu       out  1  ALU drives W bus (high)
//  Lb_bar   out  1  B register load (low)
//  Lo_bar   out  1  output register load (low)
//  HLT      out  1  halted flag (high); freezes sequencing
// BEHAVIOUR
//  Inactive word: Lm_bar=CE_bar=Li_bar=La_bar=Lb_bar=Lo_bar=1; Cp=Ep=Ei=Ea=Su=Eu=0.
//  Reset (CLR_bar low, async):
//   - t_state=6'b000001, HLT=0.
//   - All control outputs forced to the inactive word for as long as CLR_bar is low.
//   - Mid-instruction reset aborts immediately; no partial word persists.
//  Ring counter:
//   - On each negedge CLK with HLT=0, rotates left: T6 wraps to T1.
//   - Each T-state therefore contains exactly one posedge, at which registers load.
//  Control word (combinational from t_state, opcode, HLT); unlisted signals stay inactive:
//   T1 all ops:   Ep=1, Lm_bar=0          (address)
//   T2 all ops:   Cp=1                    (increment)
//   T3 all ops:   CE_bar=0, Li_bar=0      (memory -> IR)
//   LDA T4: Ei=1, Lm_bar=0 | T5: CE_bar=0, La_bar=0 | T6: none
//   ADD T4: Ei=1, Lm_bar=0 | T5: CE_bar=0, Lb_bar=0 | T6: Eu=1, La_bar=0, Su=0
//   SUB as ADD, but Su=1 throughout T4..T6
//   OUT T4: Ea=1, Lo_bar=0 | T5, T6: none
//   HLT T4: HLT latches 1 on the first negedge seen in T4 with opcode==OP_HLT
//   undefined opcodes: T4..T6 inactive (NOP), then wrap to T1
//  Halt:
//   - Once HLT=1, t_state holds at T4 and the control word is inactive.
//   - Only CLR_bar clears HLT.
//   - In the half-cycle before the latch, the T4 word is inactive.
//  Invariants (asserted in bench):
//   - t_state is always exactly one-hot.
//   - At most one of {Ep, Ei, Ea, Eu, ~CE_bar} is high in any state.
//   - opcode is ignored during T1..T3.
//  Latency: fixed at 6 T-states (6 CLK) per instruction; no stalls except HLT.
// TESTING
//  1. CLR_bar low during T5 of ADD:
//     -> t_state=000001 and inactive word immediately; HLT=0.
//     -> After release: T1 word (Ep=1, Lm_bar=0) until the first negedge, then T2.
//  2. opcode=0000 (LDA), run 6 negedges:
//     -> T4 Ei=1/Lm_bar=0; T5 CE_bar=0/La_bar=0; T6 inactive; wraps to 000001.
//  3. opcode=0001, then 0010:
//     -> T5 Lb_bar=0; T6 Eu=1, La_bar=0.
//     -> Su=0 for ADD; Su=1 during T4..T6 for SUB.
//  4. opcode=1110 (OUT):
//     -> T4 Ea=1, Lo_bar=0; T5, T6 inactive; no other bus driver active in T4.
//  5. opcode=1111 (HLT):
//     -> HLT=1 after the T4 negedge; t_state stays 001000 over 10 further clocks.
//     -> CLR_bar pulse -> HLT=0, T1.
//  6. opcode=0101 (undefined):
//     -> T4..T6 inactive; wrap to T1.
//     -> Run 100 random opcodes and assert the one-hot and single-driver invariants every cycle.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter advancing on the
// falling clock edge, plus the opcode decoder that produces the control word.
module sap1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       CE_bar,
  output logic       Li_bar,
  output logic       Ei,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic       HLT
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  ring_e state;
  ring_e state_next;
  logic  halted;
  logic  halted_next;

  // Falling-edge sequencing leaves a full half-cycle for the word to settle
  // before the rising edge at which the registers on the W bus load.
  always_ff @(negedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (!halted) begin
      case (state)
        T1: state_next = T2;
        T2: state_next = T3;
        T3: state_next = T4;
        T4: begin
          if (opcode == OP_HLT) halted_next = 1'b1;
          else                  state_next  = T5;
        end
        T5: state_next = T6;
        T6: state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  assign t_state = state;
  assign HLT     = halted;

  // Reset and halt both force the inactive word, so a held-low CLR_bar never
  // lets the T1 address word leak onto the bus.
  always_comb begin
    Cp     = 1'b0;
    Ep     = 1'b0;
    Lm_bar = 1'b1;
    CE_bar = 1'b1;
    Li_bar = 1'b1;
    Ei     = 1'b0;
    La_bar = 1'b1;
    Ea     = 1'b0;
    Su     = 1'b0;
    Eu     = 1'b0;
    Lb_bar = 1'b1;
    Lo_bar = 1'b1;
    if (CLR_bar && !halted) begin
      case (state)
        T1: begin
          Ep     = 1'b1;
          Lm_bar = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          CE_bar = 1'b0;
          Li_bar = 1'b0;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            Ei     = 1'b1;
            Lm_bar = 1'b0;
            Su     = (opcode == OP_SUB);
          end else if (opcode == OP_OUT) begin
            Ea     = 1'b1;
            Lo_bar = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            CE_bar = 1'b0;
            La_bar = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            CE_bar = 1'b0;
            Lb_bar = 1'b0;
            Su     = (opcode == OP_SUB);
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            Eu     = 1'b1;
            La_bar = 1'b0;
            Su     = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
